// File: rtl/demux_reg_if.sv
// Bundle of the demux_reg producer, consumer and status signals.
// Latency: n/a (wiring only).
// Backpressure: in_ready toward the producer, saida_ack from the consumers.
interface demux_reg_if #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 2
);
   localparam int N = 1 << SEL_W;

   logic [WIDTH-1:0]   entrada;
   logic [SEL_W-1:0]   chave;
   logic               modo;
   logic               in_valid;
   logic               in_ready;
   logic [N*WIDTH-1:0] saida;
   logic [N-1:0]       saida_valid;
   logic [N-1:0]       saida_ack;
   logic [SEL_W-1:0]   ptr;
   logic [7:0]         contador;

   // Producer/consumer side (drives words and acks).
   modport master (
      output entrada, chave, modo, in_valid, saida_ack,
      input  in_ready, saida, saida_valid, ptr, contador
   );

   // Demultiplexer side.
   modport slave (
      input  entrada, chave, modo, in_valid, saida_ack,
      output in_ready, saida, saida_valid, ptr, contador
   );
endinterface

// File: rtl/demux_reg.sv
// Registered 1-to-N demux: steers one word into a held slot chosen by chave or a round-robin ptr.
// Latency: 1 cycle from accept to the word showing on its slot.
// Backpressure: in_ready drops when the target slot is full and not being acked this cycle.
module demux_reg #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 2
) (
   input  logic         clk,
   input  logic         reset,
   demux_reg_if.slave   bus
);
   localparam int N = 1 << SEL_W;

   logic [N-1:0][WIDTH-1:0] data_q, data_d;
   logic [N-1:0]            vld_q, vld_d;
   logic [SEL_W-1:0]        ptr_q, ptr_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [SEL_W-1:0]        tgt;
   logic                    in_ready;
   logic                    accept;

   // A full slot can still take a word when its consumer drains it in the same cycle.
   assign tgt      = bus.modo ? ptr_q : bus.chave;
   assign in_ready = ~vld_q[tgt] | bus.saida_ack[tgt];
   assign accept   = bus.in_valid & in_ready;

   assign bus.in_ready    = in_ready;
   assign bus.saida       = data_q;
   assign bus.saida_valid = vld_q;
   assign bus.ptr         = ptr_q;
   assign bus.contador    = cnt_q;

   // Next state: acks clear valids (data kept), then an accept fills the target slot.
   always_comb begin
      data_d = data_q;
      vld_d  = vld_q & ~bus.saida_ack;
      ptr_d  = ptr_q;
      cnt_d  = cnt_q;
      if (accept) begin
         data_d[tgt] = bus.entrada;
         vld_d[tgt]  = 1'b1;
         cnt_d       = cnt_q + 8'd1;
         if (bus.modo) begin
            ptr_d = ptr_q + SEL_W'(1);
         end
      end
   end

   // All held state, cleared immediately by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q <= '0;
         vld_q  <= '0;
         ptr_q  <= '0;
         cnt_q  <= '0;
      end else begin
         data_q <= data_d;
         vld_q  <= vld_d;
         ptr_q  <= ptr_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

// File: tb/tb_demux_reg.sv
module tb_demux_reg;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   demux_reg_if #(.WIDTH(8), .SEL_W(2)) bus ();

   demux_reg #(.WIDTH(8), .SEL_W(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: per-slot queue of words still owed to each consumer.
   logic [7:0] exp_q[4][$];
   logic [3:0] occ  = '0;
   logic [1:0] mptr = '0;
   logic [7:0] mcnt = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [7:0] slot(input int i);
      return bus.saida[i*8 +: 8];
   endfunction

   // Model update on each edge: acks free slots, an accept queues the word for its slot.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) exp_q[i].delete();
         occ  = '0;
         mptr = '0;
         mcnt = '0;
      end else begin
         logic [1:0] t;
         logic       acc;
         t   = bus.modo ? mptr : bus.chave;
         acc = bus.in_valid && (!occ[t] || bus.saida_ack[t]);
         occ = occ & ~bus.saida_ack;
         if (acc) begin
            exp_q[t].push_back(bus.entrada);
            occ[t] = 1'b1;
            mcnt   = mcnt + 8'd1;
            if (bus.modo) mptr = 2'((int'(mptr) + 1) % 4);
         end
      end
   end

   // Monitor: compare presented slots against the model, pop words as consumers take them.
   always @(negedge clk) begin
      if (!reset) begin
         logic [1:0] t;
         t = bus.modo ? mptr : bus.chave;
         chk("valid", bus.saida_valid, occ);
         chk("ptr", bus.ptr, mptr);
         chk("contador", bus.contador, mcnt);
         chk("in_ready", bus.in_ready, !occ[t] || bus.saida_ack[t]);
         for (int i = 0; i < 4; i++) begin
            if (bus.saida_valid[i]) begin
               if (exp_q[i].size() == 0) begin
                  chk("slot_unexpected", 1, 0);
               end else begin
                  chk($sformatf("slot%0d_data", i), slot(i), exp_q[i][0]);
                  if (bus.saida_ack[i]) void'(exp_q[i].pop_front());
               end
            end
         end
      end
   end

   task automatic set_in(input logic v, input logic [7:0] d, input logic [1:0] c,
                         input logic m, input logic [3:0] a);
      bus.in_valid  = v;
      bus.entrada   = d;
      bus.chave     = c;
      bus.modo      = m;
      bus.saida_ack = a;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      set_in(0, 8'h00, 2'd0, 0, 4'h0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic hold;
      set_in(0, 8'h00, 2'd0, 0, 4'h0);
      #2;
      chk("rst_valid", bus.saida_valid, 4'h0);
      chk("rst_saida", bus.saida, 32'h0);
      do_reset();
      chk("rst_ptr", bus.ptr, 2'd0);
      chk("rst_cnt", bus.contador, 8'd0);
      chk("rst_rdy", bus.in_ready, 1'b1);

      // Manual write to slot 2.
      set_in(1, 8'hA5, 2'd2, 0, 4'h0); tick();
      set_in(0, 8'h00, 2'd2, 0, 4'h0);
      chk("m_valid", bus.saida_valid, 4'b0100);
      chk("m_slot2", slot(2), 8'hA5);
      chk("m_cnt", bus.contador, 8'd1);
      chk("m_ptr", bus.ptr, 2'd0);

      // Offer into the full slot: blocked, then pass-through with ack.
      set_in(1, 8'h3C, 2'd2, 0, 4'h0); #1;
      chk("full_rdy", bus.in_ready, 1'b0);
      tick();
      chk("full_nochg", bus.contador, 8'd1);
      set_in(1, 8'h3C, 2'd2, 0, 4'b0100); #1;
      chk("pt_rdy", bus.in_ready, 1'b1);
      tick();
      set_in(0, 8'h00, 2'd0, 0, 4'h0);
      chk("pt_slot2", slot(2), 8'h3C);
      chk("pt_valid2", bus.saida_valid[2], 1'b1);
      chk("pt_cnt", bus.contador, 8'd2);

      // Auto mode, acked the cycle after each fill.
      do_reset();
      for (int t = 0; t < 5; t++) begin
         set_in(1, 8'(t + 1), 2'd3, 1, (t > 0) ? 4'(1 << ((t - 1) % 4)) : 4'h0);
         tick();
      end
      set_in(0, 8'h00, 2'd0, 1, 4'b0001);
      chk("rr_slot0", slot(0), 8'h05);
      chk("rr_slot3", slot(3), 8'h04);
      chk("rr_ptr", bus.ptr, 2'd1);
      chk("rr_cnt", bus.contador, 8'd5);
      tick();

      // Auto mode with no acks: pointer stalls on the full slot.
      do_reset();
      for (int t = 0; t < 4; t++) begin
         set_in(1, 8'(t + 1), 2'd0, 1, 4'h0); tick();
      end
      set_in(1, 8'h05, 2'd0, 1, 4'h0); #1;
      chk("stall_valid", bus.saida_valid, 4'b1111);
      chk("stall_rdy", bus.in_ready, 1'b0);
      chk("stall_ptr", bus.ptr, 2'd0);
      tick();
      set_in(1, 8'h05, 2'd0, 1, 4'b0001); tick();
      set_in(0, 8'h00, 2'd0, 1, 4'h0);
      chk("stall_slot0", slot(0), 8'h05);
      chk("stall_ptr1", bus.ptr, 2'd1);

      // Counter wrap with every slot drained each cycle.
      do_reset();
      for (int t = 0; t < 256; t++) begin
         set_in(1, 8'($urandom), 2'($urandom), 0, 4'hF); tick();
      end
      set_in(0, 8'h00, 2'd0, 0, 4'hF); tick();
      chk("wrap_cnt", bus.contador, 8'd0);
      chk("wrap_valid", bus.saida_valid, 4'h0);
      tick();
      set_in(0, 8'h00, 2'd0, 0, 4'h0);
      chk("empty_ack_valid", bus.saida_valid, 4'h0);
      chk("empty_ack_cnt", bus.contador, 8'd0);

      // Random traffic; producer holds its word while blocked.
      do_reset();
      hold = 1'b0;
      for (int t = 0; t < 3000; t++) begin
         if (!hold) begin
            set_in(($urandom % 4) != 0, 8'($urandom), 2'($urandom), 1'($urandom), 4'($urandom));
         end else begin
            bus.saida_ack = 4'($urandom);
         end
         #1;
         hold = bus.in_valid && !bus.in_ready;
         tick();
      end

      // Asynchronous reset between edges with three slots full.
      do_reset();
      for (int c = 0; c < 3; c++) begin
         set_in(1, 8'(8'h10 + c), 2'(c), 0, 4'h0); tick();
      end
      set_in(0, 8'h00, 2'd0, 0, 4'h0);
      chk("pre_async_valid", bus.saida_valid, 4'b0111);
      #1;
      reset = 1'b1;
      #1;
      chk("async_valid", bus.saida_valid, 4'h0);
      chk("async_saida", bus.saida, 32'h0);
      chk("async_ptr", bus.ptr, 2'd0);
      chk("async_cnt", bus.contador, 8'd0);
      set_in(0, 8'h00, 2'd0, 0, 4'hF);
      tick();
      reset = 1'b0;
      set_in(0, 8'h00, 2'd0, 0, 4'h0);

      // Walk chave over every slot and show the outputs.
      for (int c = 0; c < 4; c++) begin
         set_in(1, 8'(8'hC0 + c), 2'(c), 0, 4'h0); tick();
         $display("chave=%0d in_ready=%0b saida=%h saida_valid=%b ptr=%0d contador=%0d",
                  c, bus.in_ready, bus.saida, bus.saida_valid, bus.ptr, bus.contador);
      end
      set_in(0, 8'h00, 2'd0, 0, 4'h0);
      chk("walk_valid", bus.saida_valid, 4'hF);
      chk("walk_slot3", slot(3), 8'hC3);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/demux_reg.md
Name: demux_reg

Overview:
- Registered 1-to-N demultiplexer with a valid/ack handshake. It is the distributing counterpart of the team's 2:1 selector (`mux`): it takes one input word and steers it into one of N held output slots.
- The target slot comes either from the `chave` select input (manual mode) or from an internal round-robin pointer (auto mode).
- Sits between a single producer and N consumers in the datapath exercises. Each consumer drains its own slot independently.

Parameters:
- WIDTH, 8, data width of each word.
- SEL_W, 2, select width; N = 2**SEL_W output slots (default 4).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- entrada  input  WIDTH  input data word.
- chave  input  SEL_W  slot select, used only when modo=0.
- modo  input  1  0 = manual (chave selects), 1 = auto (round-robin pointer selects).
- in_valid  input  1  producer offers entrada this cycle.
- in_ready  output  1  block accepts the word this cycle (combinational).
- saida  output  N*WIDTH  slot data, flattened; slot i is bits [i*WIDTH +: WIDTH].
- saida_valid  output  N  slot i holds an unconsumed word.
- saida_ack  input  N  consumer i takes slot i's word this cycle.
- ptr  output  SEL_W  current round-robin pointer.
- contador  output  8  count of accepted words, wraps modulo 256.

Behaviour:
- Reset (asynchronous, active-high):
  - Forces saida=0, saida_valid=0, ptr=0, contador=0 immediately, without waiting for a clock edge.
  - Mid-operation reset discards every held word. Acks during reset are ignored.
  - The first accept is possible on the first rising edge after reset deasserts.
- Target slot: tgt = modo ? ptr : chave.
- in_ready = ~saida_valid[tgt] | saida_ack[tgt].
  - Combinational on modo, chave, ptr, saida_valid and saida_ack.
  - Has no dependency on in_valid.
- accept = in_valid & in_ready. On the rising edge with accept:
  - slot tgt data <= entrada;
  - saida_valid[tgt] <= 1;
  - contador <= contador+1 (wraps 255 -> 0);
  - if modo=1: ptr <= ptr+1 modulo N (wraps N-1 -> 0).
- Latency: a word accepted at edge k appears on saida and saida_valid right after edge k (1 cycle).
- Consumer ack:
  - saida_ack[i] & saida_valid[i] with no accept into slot i: saida_valid[i] <= 0. Data is retained, not cleared.
  - Ack on an empty slot is ignored.
- Simultaneous ack and accept on the same full slot: valid stays 1 and data is replaced by the new word (pass-through, no bubble).
- Acks on several slots in the same cycle are all honoured, independent of any accept into another slot.
- Full slot with no ack: in_ready=0 and there is no state change. The producer must hold entrada, chave and modo stable while in_valid=1 and in_ready=0.
- Auto mode:
  - The pointer does not skip full slots; it stalls on the full slot until that slot is acked.
  - ptr changes only on accept with modo=1. Switching modo retains ptr.
  - In manual mode ptr holds its value.
- in_valid=0: no state change except ack clears.
- Implementation: all registered state in one always block on posedge clk or posedge reset. in_ready, tgt and the flattened saida are continuous assigns.

Test Plan:
- Reset, then modo=0, chave=2, entrada=8'hA5, in_valid pulsed 1 cycle -> saida_valid=4'b0100, slot2=A5, contador=1, ptr=0.
- Slot2 still full, second offer 8'h3C to chave=2 with no ack -> in_ready=0. Then ack[2] in the same cycle as the offer -> in_ready=1, slot2=3C, valid[2] stays 1, contador=2.
- modo=1, 5 back-to-back words 01..05, every slot acked the cycle after it fills -> slots 0..3 get 01..04, slot0 then gets 05, ptr=1 at the end, contador=5.
- modo=1, no acks, 5 offers held -> 4 accepted (saida_valid=4'b1111), in_ready=0 with ptr=0. Ack[0] -> word 05 enters slot0, ptr=1.
- 256 accepts with immediate acks -> contador wraps to 0. Ack on an empty slot -> no change.
- Assert reset asynchronously between edges with 3 slots full -> saida_valid=0, saida=0, ptr=0 and contador=0 before the next edge. Run an exhaustive loop over chave 0..3 with `$display` of the outputs.
